// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the whack-a-target round sequencer.
// Also holds the target/colour pick helpers used on the GAP->SHOW load.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    SHOW = 3'd2,
    BOOM = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam int          CNT_W         = 24;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [1:0]  COLOR_DEFAULT = 2'b01;
  localparam logic [7:0]  SCORE_MAX     = 8'hFF;

  // Never repeat the previous cell: bump the candidate by one when it collides.
  function automatic logic [3:0] pick_pos(input logic [3:0] cand, input logic [3:0] prev);
    return (cand == prev) ? cand + 4'd1 : cand;
  endfunction

  // Colour 0 is "off" on the matrix, so fold it onto the default colour.
  function automatic logic [1:0] pick_color(input logic [1:0] raw);
    return (raw == 2'b00) ? COLOR_DEFAULT : raw;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Key-decoder, display-controller and status signals of the round sequencer.
// master = the sequencer, slave = keypad/display/segment side.
interface game_round_ctrl_if;
  logic       start;
  logic       hitValid;
  logic [3:0] hitPos;
  logic       finishBoom;
  logic       en;
  logic [3:0] pos;
  logic [1:0] color;
  logic       showBoom;
  logic [7:0] score;
  logic [1:0] lives;
  logic       gameOver;
  logic       busy;

  modport master (
    input  start, hitValid, hitPos, finishBoom,
    output en, pos, color, showBoom, score, lives, gameOver, busy
  );

  modport slave (
    output start, hitValid, hitPos, finishBoom,
    input  en, pos, color, showBoom, score, lives, gameOver, busy
  );
endinterface

// File: rtl/game_round_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR, shifting right; never stops so player
// timing perturbs which value is sampled at target load.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: picks targets, times rounds, judges hits, keeps score/lives.
// All outputs are registered; one FSM process owns state, counter and score.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES     = 2_000_000,
  parameter int unsigned LIVES          = 3,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  game_round_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LIVES_INI = 2'(LIVES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      lfsr;
  logic             en_q, boom_q, over_q, busy_q;
  logic [3:0]       pos_q;
  logic [1:0]       color_q;
  logic [7:0]       score_q;
  logic [1:0]       lives_q;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      en_q    <= 1'b0;
      boom_q  <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      pos_q   <= 4'd0;
      color_q <= COLOR_DEFAULT;
      score_q <= 8'd0;
      lives_q <= LIVES_INI;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            score_q <= 8'd0;
            lives_q <= LIVES_INI;
            cnt     <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= '0;
            pos_q   <= pick_pos(lfsr[5:2], pos_q);
            color_q <= pick_color(lfsr[7:6]);
            en_q    <= 1'b1;
            state   <= SHOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          // A hit is checked first so it beats a timeout in the same cycle.
          if (bus.hitValid && bus.hitPos == pos_q) begin
            score_q <= (score_q == SCORE_MAX) ? score_q : score_q + 8'd1;
            boom_q  <= 1'b1;
            state   <= BOOM;
          end else if (bus.hitValid || cnt == TO_LAST) begin
            lives_q <= lives_q - 2'd1;
            en_q    <= 1'b0;
            cnt     <= '0;
            if (lives_q == 2'd1) begin
              over_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= OVER;
            end else begin
              state  <= GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BOOM: begin
          // The falling showBoom is what rearms the display animation.
          if (bus.finishBoom) begin
            boom_q <= 1'b0;
            en_q   <= 1'b0;
            cnt    <= '0;
            state  <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.en       = en_q;
  assign bus.pos      = pos_q;
  assign bus.color    = color_q;
  assign bus.showBoom = boom_q;
  assign bus.score    = score_q;
  assign bus.lives    = lives_q;
  assign bus.gameOver = over_q;
  assign bus.busy     = busy_q;

endmodule
